// File: rtl/msd_pkg.sv
// rtl/msd_pkg.sv - shared types, op encodings, address fields and default DDR5 timings
package msd_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD0  = 3'd3,
    CMD_RD1  = 3'd4,
    CMD_WR0  = 3'd5,
    CMD_WR1  = 3'd6,
    CMD_PRE  = 3'd7
  } cmd_e;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_IF  = 2'd2;
  localparam logic [1:0] OP_ILL = 2'd3;

  localparam int ADDR_W   = 36;
  localparam int CHAN_LSB = 6;
  localparam int CHAN_W   = 1;
  localparam int BG_LSB   = 7;
  localparam int BG_W     = 3;
  localparam int BANK_LSB = 10;
  localparam int BANK_W   = 2;
  localparam int COL_LSB  = 12;
  localparam int COL_W    = 6;
  localparam int ROW_LSB  = 18;
  localparam int ROW_W    = 16;

  localparam int DEF_T_RCD   = 39;
  localparam int DEF_T_RAS   = 76;
  localparam int DEF_T_RTP   = 18;
  localparam int DEF_T_CWL   = 38;
  localparam int DEF_T_BURST = 8;
  localparam int DEF_T_WR    = 48;
  localparam int DEF_T_RP    = 39;
  localparam int DEF_CNT_W   = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msd_addr_map.sv
// rtl/msd_addr_map.sv - combinational physical address to chan/bg/bank/row/col decode
module msd_addr_map
  import msd_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic              chan_o,
  output logic [BG_W-1:0]   bg_o,
  output logic [BANK_W-1:0] bank_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o
);

  // bits below the channel select and above the row are not used by the DRAM mapping
  logic unused_bits;
  assign unused_bits = ^{addr_i[ADDR_W-1:ROW_LSB+ROW_W], addr_i[CHAN_LSB-1:0]};

  assign chan_o = addr_i[CHAN_LSB];
  assign bg_o   = addr_i[BG_LSB +: BG_W];
  assign bank_o = addr_i[BANK_LSB +: BANK_W];
  assign row_o  = addr_i[ROW_LSB +: ROW_W];
  assign col_o  = addr_i[COL_LSB +: COL_W];

endmodule

// File: rtl/msd_cmd_sequencer.sv
// rtl/msd_cmd_sequencer.sv - closed-page ACT/CAS/PRE sequencer; optional trace via MSD_CMD_TRACE_EN
module msd_cmd_sequencer
  import msd_pkg::*;
#(
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RAS   = DEF_T_RAS,
  parameter int T_RTP   = DEF_T_RTP,
  parameter int T_CWL   = DEF_T_CWL,
  parameter int T_BURST = DEF_T_BURST,
  parameter int T_WR    = DEF_T_WR,
  parameter int T_RP    = DEF_T_RP,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              cmd_valid,
  output cmd_e              cmd,
  output logic              cmd_chan,
  output logic [BG_W-1:0]   cmd_bg,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [COL_W-1:0]  cmd_col,
  output logic              busy,
  output logic              err_op
);

  // PRE distance is a sum of up to four timings, so it gets two extra bits
  localparam int PW   = CNT_W + 2;
  localparam int P_RD = max_int(T_RAS, T_RCD + T_RTP);
  localparam int P_WR = T_RCD + T_CWL + T_BURST + T_WR;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_e;

  state_e              state_q, state_d;
  logic                chan_q, chan_d, wr_q, wr_d, err_q, err_d;
  logic [BG_W-1:0]     bg_q, bg_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                dec_chan, accept;
  logic [BG_W-1:0]     dec_bg;
  logic [BANK_W-1:0]   dec_bank;
  logic [ROW_W-1:0]    dec_row;
  logic [COL_W-1:0]    dec_col;
  logic                cmd_valid_d;
  cmd_e                cmd_d;

  msd_addr_map u_addr_map (
    .addr_i (req_addr),
    .chan_o (dec_chan),
    .bg_o   (dec_bg),
    .bank_o (dec_bank),
    .row_o  (dec_row),
    .col_o  (dec_col)
  );

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign err_op    = err_q;
  assign accept    = req_valid && req_ready;

  // next state, request capture and sticky illegal-op flag
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    bg_d    = bg_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_op == OP_ILL) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ACT0;
            chan_d  = dec_chan;
            bg_d    = dec_bg;
            bank_d  = dec_bank;
            row_d   = dec_row;
            col_d   = dec_col;
            wr_d    = (req_op == OP_WR);
          end
        end
      end
      S_ACT0:     state_d = S_ACT1;
      S_ACT1:     state_d = (tcnt_q == '0) ? S_CAS0 : S_WAIT_RCD;
      S_WAIT_RCD: if (tcnt_q == '0) state_d = S_CAS0;
      S_CAS0:     state_d = S_CAS1;
      S_CAS1:     state_d = (pcnt_q == '0) ? S_PRE : S_WAIT_PRE;
      S_WAIT_PRE: if (pcnt_q == '0) state_d = S_PRE;
      S_PRE:      state_d = (tcnt_q == '0) ? S_IDLE : S_WAIT_RP;
      S_WAIT_RP:  if (tcnt_q == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // tRCD/tRP share one counter; the PRE counter runs from ACT0 independently
  always_comb begin
    tcnt_d = (tcnt_q != '0) ? tcnt_q - 1'b1 : tcnt_q;
    pcnt_d = (pcnt_q != '0) ? pcnt_q - 1'b1 : pcnt_q;
    if (state_d == S_ACT0 && state_q == S_IDLE) begin
      tcnt_d = CNT_W'(T_RCD - 1);
      pcnt_d = wr_d ? PW'(P_WR - 1) : PW'(P_RD - 1);
    end else if (state_d == S_PRE) begin
      tcnt_d = CNT_W'(T_RP - 2);
    end
  end

  // command decode from the upcoming state so the outputs can be registered
  always_comb begin
    cmd_valid_d = 1'b1;
    cmd_d       = CMD_NOP;
    case (state_d)
      S_ACT0:  cmd_d = CMD_ACT0;
      S_ACT1:  cmd_d = CMD_ACT1;
      S_CAS0:  cmd_d = wr_d ? CMD_WR0 : CMD_RD0;
      S_CAS1:  cmd_d = wr_d ? CMD_WR1 : CMD_RD1;
      S_PRE:   cmd_d = CMD_PRE;
      default: cmd_valid_d = 1'b0;
    endcase
  end

  // state, request fields and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= 1'b0;
      bg_q    <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      bg_q    <= bg_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // registered command bus; address fields forced to zero on NOP cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      cmd_chan  <= 1'b0;
      cmd_bg    <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
    end else begin
      cmd_valid <= cmd_valid_d;
      cmd       <= cmd_d;
      cmd_chan  <= cmd_valid_d ? chan_d : 1'b0;
      cmd_bg    <= cmd_valid_d ? bg_d   : '0;
      cmd_bank  <= cmd_valid_d ? bank_d : '0;
      cmd_row   <= cmd_valid_d ? row_d  : '0;
      cmd_col   <= cmd_valid_d ? col_d  : '0;
    end
  end

`ifdef MSD_CMD_TRACE_EN
  logic [63:0] cycle_q;

  // cycle-stamped command log and illegal-op report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (cmd_valid) begin
        if (cmd == CMD_PRE)
          $display("%0d %0d %s %0d %0d", cycle_q, cmd_chan, cmd.name(), cmd_bg, cmd_bank);
        else if (cmd == CMD_ACT0 || cmd == CMD_ACT1)
          $display("%0d %0d %s %0d %0d %0d", cycle_q, cmd_chan, cmd.name(), cmd_bg, cmd_bank, cmd_row);
        else
          $display("%0d %0d %s %0d %0d %0d", cycle_q, cmd_chan, cmd.name(), cmd_bg, cmd_bank, cmd_col);
      end
      if (err_d && !err_q)
        $display("%0d error: illegal op 3 accepted", cycle_q);
    end
  end
`else
  // trace disabled: no cycle counter, no simulation output
`endif

endmodule

// File: tb/tb_msd_cmd_sequencer.sv
// tb/tb_msd_cmd_sequencer.sv - scoreboard bench for msd_cmd_sequencer
module tb_msd_cmd_sequencer;
  import msd_pkg::*;

  typedef struct {
    int           cyc;
    logic [2:0]   cmd;
    logic [27:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic              req_valid = 1'b0, b_valid = 1'b0;
  logic [1:0]        req_op = 2'd0, b_op = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0, b_addr = '0;
  logic              req_ready, b_ready;
  logic              cmd_valid, b_cmd_valid;
  cmd_e              cmd, b_cmd;
  logic              cmd_chan, b_chan;
  logic [2:0]        cmd_bg, b_bg;
  logic [1:0]        cmd_bank, b_bank;
  logic [15:0]       cmd_row, b_row;
  logic [5:0]        cmd_col, b_col;
  logic              busy, b_busy, err_op, b_err;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msd_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_chan(cmd_chan), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .busy(busy), .err_op(err_op)
  );

  msd_cmd_sequencer #(.T_RAS(40)) dut_ras (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_addr(b_addr), .cmd_valid(b_cmd_valid), .cmd(b_cmd),
    .cmd_chan(b_chan), .cmd_bg(b_bg), .cmd_bank(b_bank), .cmd_row(b_row),
    .cmd_col(b_col), .busy(b_busy), .err_op(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] fmask(input logic [2:0] c);
    if (c == CMD_ACT0 || c == CMD_ACT1) return 28'hFFFFFC0;
    if (c == CMD_PRE) return 28'hFC00000;
    return 28'hFC0003F;
  endfunction

  // expected command train for one request accepted in cycle c
  task automatic push_req(input int k, input int c, input logic [1:0] op,
                          input logic [35:0] a, input int pre_off);
    exp_t e;
    logic [27:0] f;
    f = {a[6], a[9:7], a[11:10], a[33:18], a[17:12]};
    e.f = f;
    e.cyc = c + 1;  e.cmd = CMD_ACT0;  if (k == 0) q0.push_back(e); else q1.push_back(e);
    e.cyc = c + 2;  e.cmd = CMD_ACT1;  if (k == 0) q0.push_back(e); else q1.push_back(e);
    e.cyc = c + 40; e.cmd = (op == 2'd1) ? CMD_WR0 : CMD_RD0;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    e.cyc = c + 41; e.cmd = (op == 2'd1) ? CMD_WR1 : CMD_RD1;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    e.cyc = c + pre_off; e.cmd = CMD_PRE;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic mon(input int k, input logic v, input logic [2:0] c, input logic [27:0] f);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        chk($sformatf("unexpected_cmd%0d", k), {61'd0, c}, 64'd0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("cmd_cycle%0d", k), cyc, e.cyc);
        chk($sformatf("cmd_code%0d", k), c, e.cmd);
        chk($sformatf("cmd_fields%0d", k), f & fmask(e.cmd), e.f & fmask(e.cmd));
      end
    end else begin
      chk($sformatf("nop_outputs%0d", k), {c, f}, 64'd0);
      if (n > 0) begin
        e = (k == 0) ? q0[0] : q1[0];
        if (e.cyc <= cyc) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("missed_cmd%0d", k), {61'd0, c}, e.cmd);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, cmd_valid, cmd, {cmd_chan, cmd_bg, cmd_bank, cmd_row, cmd_col});
      mon(1, b_cmd_valid, b_cmd, {b_chan, b_bg, b_bank, b_row, b_col});
    end
  end

  task automatic issue(input int k, input logic [1:0] op, input logic [35:0] a,
                       input int pre_off, input bit hold, output int c);
    int n;
    n = 0;
    while (((k == 0) ? req_ready : b_ready) !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("ready_timeout", (k == 0) ? req_ready : b_ready, 1);
    if (k == 0) begin req_valid = 1'b1; req_op = op; req_addr = a; end
    else begin b_valid = 1'b1; b_op = op; b_addr = a; end
    c = cyc;
    if (op != 2'd3) push_req(k, c, op, a, pre_off);
    @(negedge clk);
    if (!hold) begin req_valid = 1'b0; b_valid = 1'b0; end
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain%0d", k), (k == 0) ? q0.size() : q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c, c2, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_bus", {cmd, cmd_chan, cmd_bg, cmd_bank, cmd_row, cmd_col}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_op, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // read: ACT0 c+1 .. PRE c+77
    issue(0, 2'd0, 36'h0_0004_2380, 77, 0, c);
    chk("busy_after_accept", busy, 1);
    chk("ready_low_in_flight", req_ready, 0);
    drain(0);

    // write: PRE at c+134
    issue(0, 2'd1, 36'h0_0004_2380, 134, 0, c);
    drain(0);

    // op 2 then back-to-back read: second ACT0 at first PRE + 39
    issue(0, 2'd2, 36'h3_ABCD_1F40, 77, 1, c);
    req_op = 2'd0;
    req_addr = 36'h2_5555_AAC0;
    c2 = c + 77 + 38;
    push_req(0, c2, 2'd0, 36'h2_5555_AAC0, 77);
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_accept_cycle", cyc, c2);
    @(negedge clk);
    req_valid = 1'b0;
    drain(0);

    // illegal op: no commands, sticky error, still ready
    issue(0, 2'd3, 36'h1_2345_6789, 0, 0, c);
    chk("ill_err", err_op, 1);
    chk("ill_ready", req_ready, 1);
    chk("ill_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("ill_err_sticky", err_op, 1);
    issue(0, 2'd0, 36'h0_FFFF_FFC0, 77, 0, c);
    drain(0);

    // reset 5 cycles after RD1: no PRE, back to idle
    issue(0, 2'd0, 36'h1_0F0F_0C40, 77, 0, c);
    while (cyc < c + 41 + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_err_cleared", err_op, 0);
    chk("midrst_pending_pre", q0.size(), 1);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // T_RAS=40: tRCD+tRTP dominates, PRE at ACT0+57
    issue(1, 2'd0, 36'h0_0004_2380, 58, 0, c);
    drain(1);

    chk("final_q0_empty", q0.size(), 0);
    chk("final_q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
